// File: rtl/out_stream.sv
// Output-channel buffer: captures words emitted by the core into a FIFO and replays
// them over a valid/ready stream, tracking end-of-program drain and sticky error flags.
module out_stream #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned Depth              = 8,
    parameter int unsigned CountWidth         = $clog2(Depth) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          out_write,
    input  logic [MemoryElementWidth-1:0] out_data,
    input  logic                          finished,
    output logic                          stream_valid,
    output logic [MemoryElementWidth-1:0] stream_data,
    input  logic                          stream_ready,
    output logic [CountWidth-1:0]         count,
    output logic                          full,
    output logic                          overflow,
    output logic                          late_write,
    output logic [15:0]                   written,
    output logic                          drained
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [MemoryElementWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]           rd_ptr_q, wr_ptr_q;
    logic [CountWidth-1:0]         count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          late_q, late_d;
    logic [15:0]                   written_q, written_d;
    logic                          drained_q, drained_d;
    logic                          accepting, full_w, push, pop;

    always_comb begin
        accepting  = (state_q == IDLE) || (state_q == RUN);
        full_w     = (count_q == CountWidth'(Depth));
        pop        = (count_q != '0) && stream_ready;
        push       = out_write && accepting && (!full_w || pop);
        count_d    = count_q + CountWidth'(push) - CountWidth'(pop);
        overflow_d = overflow_q | (out_write && accepting && !push);
        late_d     = late_q | (out_write && !accepting);
        written_d  = push ? written_q + 16'd1 : written_q;

        // The push is folded into count_d first, so finished sees post-edge occupancy.
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (finished)  state_d = (count_d != '0) ? DRAIN : DONE;
                else if (push) state_d = RUN;
            end
            DRAIN:   if (count_d == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        drained_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
            written_q  <= '0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            late_q     <= late_d;
            written_q  <= written_d;
            drained_q  <= drained_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    assign stream_valid = (count_q != '0);
    assign stream_data  = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign full         = full_w;
    assign overflow     = overflow_q;
    assign late_write   = late_q;
    assign written      = written_q;
    assign drained      = drained_q;

endmodule

// File: tb/tb_out_stream.sv
// Self-checking bench for out_stream: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_out_stream;

    localparam int W = 12;
    localparam int D = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          out_write = 1'b0;
    logic [W-1:0]  out_data = '0;
    logic          finished = 1'b0;
    logic          stream_ready = 1'b0;
    logic          stream_valid;
    logic [W-1:0]  stream_data;
    logic [CW-1:0] count;
    logic          full, overflow, late_write, drained;
    logic [15:0]   written;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    out_stream #(.MemoryElementWidth(W), .Depth(D)) dut (
        .clock(clock), .reset(reset), .out_write(out_write), .out_data(out_data),
        .finished(finished), .stream_valid(stream_valid), .stream_data(stream_data),
        .stream_ready(stream_ready), .count(count), .full(full), .overflow(overflow),
        .late_write(late_write), .written(written), .drained(drained)
    );

    always #5 clock = ~clock;

    // Reference model: a queue plus "finish seen" and "done" flags.
    logic [W-1:0] q[$];
    bit           m_ov = 0, m_lw = 0, m_fin = 0, m_done = 0;
    logic [15:0]  m_wr = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ov = 0; m_lw = 0; m_fin = 0; m_done = 0; m_wr = '0;
        end else begin
            bit do_pop, do_push;
            do_pop  = (q.size() != 0) && stream_ready;
            do_push = out_write && !m_fin && ((q.size() < D) || do_pop);
            if (out_write && m_fin) m_lw = 1;
            if (out_write && !m_fin && !do_push) m_ov = 1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(out_data);
                m_wr = m_wr + 16'd1;
            end
            if (finished) m_fin = 1;
            if (m_fin && q.size() == 0) m_done = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("valid", 32'(stream_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("data", 32'(stream_data), 32'(q[0]));
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == D));
            chk("overflow", 32'(overflow), 32'(m_ov));
            chk("late_write", 32'(late_write), 32'(m_lw));
            chk("written", 32'(written), 32'(m_wr));
            chk("drained", 32'(drained), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        out_write = 0; finished = 0; stream_ready = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic rdy);
        out_write = 1; out_data = d; stream_ready = rdy;
        tick();
        out_write = 0;
    endtask

    initial begin
        tick();
        started = 1;
        reset = 0;
        chk("rst_valid", 32'(stream_valid), 0);
        chk("rst_data", 32'(stream_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drained", 32'(drained), 0);

        // Single word
        push_word(12'd5, 1'b1);
        chk("sw_valid", 32'(stream_valid), 1);
        chk("sw_data", 32'(stream_data), 5);
        chk("sw_written", 32'(written), 1);
        tick();
        chk("sw_empty", 32'(count), 0);
        finished = 1;
        tick();
        chk("sw_drained", 32'(drained), 1);

        // Fill and overflow
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            push_word(W'(i), 1'b0);
            if (i == 8) chk("fill_full", 32'(full), 1);
        end
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_count", 32'(count), 8);
        chk("fill_written", 32'(written), 8);
        stream_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("fill_order", 32'(stream_data), 32'(i));
            tick();
        end
        chk("fill_drain_count", 32'(count), 0);

        // Push and pop when full
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(W'(i), 1'b0);
        push_word(12'd9, 1'b1);
        chk("pp_count", 32'(count), 8);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_written", 32'(written), 9);
        stream_ready = 1;
        for (int i = 2; i <= 9; i++) begin
            chk("pp_order", 32'(stream_data), 32'(i));
            tick();
        end

        // Drain after finish, then late write
        do_reset();
        for (int i = 0; i < 3; i++) push_word(W'(20 + i), 1'b0);
        finished = 1;
        tick();
        finished = 0;
        tick();
        tick();
        chk("dr_wait", 32'(drained), 0);
        stream_ready = 1;
        tick();
        chk("dr_pop1", 32'(drained), 0);
        tick();
        chk("dr_pop2", 32'(drained), 0);
        tick();
        chk("dr_pop3", 32'(drained), 1);
        push_word(12'd7, 1'b1);
        chk("late_flag", 32'(late_write), 1);
        chk("late_count", 32'(count), 0);
        chk("late_written", 32'(written), 3);

        // Full-rate push/pop with pointer wrap
        do_reset();
        stream_ready = 1;
        for (int i = 0; i < 20; i++) begin
            push_word(W'(100 + i), 1'b1);
            chk("wrap_head", 32'(stream_data), 32'(100 + i));
        end
        tick();
        chk("wrap_written", 32'(written), 20);
        chk("wrap_count", 32'(count), 0);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) push_word(W'(40 + i), 1'b0);
        @(posedge clock);
        #2 reset = 1;
        #1;
        chk("ar_valid", 32'(stream_valid), 0);
        chk("ar_data", 32'(stream_data), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_written", 32'(written), 0);
        reset = 0;
        @(negedge clock);
        #1;
        push_word(12'd11, 1'b0);
        chk("ar_first", 32'(stream_data), 11);
        chk("ar_count1", 32'(count), 1);

        // Randomized traffic with occasional finish and reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_write    = ($urandom_range(0, 99) < 55);
            out_data     = W'($urandom);
            stream_ready = ($urandom_range(0, 99) < 50);
            finished     = ($urandom_range(0, 99) < 2);
            reset        = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0; out_write = 0; finished = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
